// File: rtl/test_multiplo_pkg.sv
// Shared types and widths for the multiple-of checker.
// Build option TEST_MULTIPLO_FAST_EN selects the single-cycle modulo datapath.
package test_multiplo_pkg;

  localparam int unsigned X_W = 4;
  localparam int unsigned Y_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/test_multiplo_dp.sv
// Datapath: operand registers, repeated-subtraction divider and m/ok result registers.
// With TEST_MULTIPLO_FAST_EN defined the result comes from a one-cycle modulo instead.
module test_multiplo_dp
  import test_multiplo_pkg::*;
(
  input  logic           clock,
  input  logic           reset_,
  input  logic           load,
  input  logic           calc,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic           m,
  output logic           ok,
  output logic           done_c
);

  logic [X_W-1:0] xr;
  logic [Y_W-1:0] yr;
  logic [X_W-1:0] yw;
  logic           res_c;

  assign yw = X_W'(yr);

`ifdef TEST_MULTIPLO_FAST_EN
  assign done_c = 1'b1;
  assign res_c  = (yr != '0) && ((xr % yw) == '0);
`else
  // Stop once the remainder drops below the divisor; a zero remainder means exact multiple.
  assign done_c = (yr == '0) || (xr < yw);
  assign res_c  = (yr != '0) && (xr == '0);
`endif

  always_ff @(posedge clock) begin
    if (!reset_) begin
      xr <= '0;
      yr <= '0;
      m  <= 1'b0;
      ok <= 1'b0;
    end else if (load) begin
      xr <= x;
      yr <= y;
      ok <= 1'b0;
    end else if (calc) begin
      if (done_c) begin
        m  <= res_c;
        ok <= 1'b1;
      end else begin
        xr <= xr - yw;
      end
    end
  end

endmodule

// File: rtl/test_multiplo.sv
// Top: 4-phase dav_/rfd consumer FSM driving the test_multiplo_dp datapath.
// Define TEST_MULTIPLO_FAST_EN for the single-cycle result build.
module test_multiplo
  import test_multiplo_pkg::*;
(
  input  logic           clock,
  input  logic           reset_,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           dav_,
  output logic           rfd,
  output logic           m,
  output logic           ok
);

  state_t state;
  state_t next_state;
  logic   load_c;
  logic   calc_c;
  logic   done_c;

  test_multiplo_dp u_dp (
    .clock  (clock),
    .reset_ (reset_),
    .load   (load_c),
    .calc   (calc_c),
    .x      (x),
    .y      (y),
    .m      (m),
    .ok     (ok),
    .done_c (done_c)
  );

  // State register; rfd is registered from the next state so it is high exactly in S_IDLE.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state <= S_IDLE;
      rfd   <= 1'b1;
    end else begin
      state <= next_state;
      rfd   <= (next_state == S_IDLE);
    end
  end

  always_comb begin
    next_state = state;
    load_c     = 1'b0;
    calc_c     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!dav_) begin
          load_c     = 1'b1;
          next_state = S_CALC;
        end
      end
      S_CALC: begin
        // dav_ is deliberately ignored here; only the datapath decides when we finish.
        calc_c = 1'b1;
        if (done_c) next_state = S_DONE;
      end
      S_DONE: begin
        if (dav_) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_test_multiplo.sv
// Directed self-checking bench for test_multiplo (handshake, latency, results, reset).
// Expected latencies collapse to one cycle when TEST_MULTIPLO_FAST_EN is defined.
module tb_test_multiplo;

  logic       clock;
  logic       reset_;
  logic [3:0] x;
  logic [2:0] y;
  logic       dav_;
  logic       rfd;
  logic       m;
  logic       ok;

  int checks;
  int errors;
  int ok_rises;
  int txns;
  logic ok_prev;

  test_multiplo dut (
    .clock  (clock),
    .reset_ (reset_),
    .x      (x),
    .y      (y),
    .dav_   (dav_),
    .rfd    (rfd),
    .m      (m),
    .ok     (ok)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count ok rising edges to catch lost or duplicated results.
  always @(posedge clock) begin
    #2;
    if (ok === 1'b1 && ok_prev === 1'b0) ok_rises++;
    ok_prev = ok;
  end

  // One transaction; lat is cycles from acceptance edge E to the ok edge.
  // early_at>0 raises dav_ that many cycles after E; hold keeps dav_ low extra cycles in S_DONE.
  task automatic do_txn(input logic [3:0] xv, input logic [2:0] yv, input logic exp_m,
                        input int lat, input int early_at, input int hold, input string name);
    int  cyc;
    bit  seen;
    bit  rfd_bad;
    int  exp_lat;
    exp_lat = lat;
`ifdef TEST_MULTIPLO_FAST_EN
    exp_lat = 1;
`endif
    @(negedge clock);
    x = xv; y = yv; dav_ = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (rfd !== 1'b0 || ok !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: rfd=%b ok=%b required rfd=0 ok=0", name, rfd, ok);
    end
    x = 4'hx; y = 3'hx;
    cyc = 0; seen = 0; rfd_bad = 0;
    while (cyc < 40 && !seen) begin
      @(posedge clock); #1;
      cyc++;
      if (rfd !== 1'b0) rfd_bad = 1;
      if (ok === 1'b1) seen = 1;
      else if (early_at > 0 && cyc == early_at) dav_ = 1'b1;
    end
    checks++;
    if (!seen || cyc != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0d) required %0d", name, cyc, seen, exp_lat);
    end
    checks++;
    if (rfd_bad) begin
      errors++;
      $display("FAIL %s rfd_early: rfd rose before ok, required rfd=0 until ok", name);
    end
    checks++;
    if (m !== exp_m) begin
      errors++;
      $display("FAIL %s m: got %b required %b", name, m, exp_m);
    end
    if (!dav_) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clock); #1;
        checks++;
        if (rfd !== 1'b0 || ok !== 1'b1 || m !== exp_m) begin
          errors++;
          $display("FAIL %s hold: rfd=%b ok=%b m=%b required rfd=0 ok=1 m=%b", name, rfd, ok, m, exp_m);
        end
      end
      dav_ = 1'b1;
    end
    @(posedge clock); #1;
    checks++;
    if (rfd !== 1'b1 || ok !== 1'b1 || m !== exp_m) begin
      errors++;
      $display("FAIL %s release: rfd=%b ok=%b m=%b required rfd=1 ok=1 m=%b", name, rfd, ok, m, exp_m);
    end
    txns++;
  endtask

  task automatic test_reset();
    reset_ = 1'b0; dav_ = 1'b1; x = '0; y = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_ = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (rfd !== 1'b1 || ok !== 1'b0 || m !== 1'b0) begin
      errors++;
      $display("FAIL reset: rfd=%b ok=%b m=%b required rfd=1 ok=0 m=0", rfd, ok, m);
    end
  endtask

  task automatic test_basic();
    do_txn(4'd12, 3'd4, 1'b1, 4, 0, 0, "x12_y4");
    do_txn(4'd13, 3'd5, 1'b0, 3, 0, 0, "x13_y5");
    do_txn(4'd15, 3'd1, 1'b1, 16, 0, 0, "x15_y1");
    do_txn(4'd0, 3'd3, 1'b1, 1, 0, 0, "x0_y3");
  endtask

  task automatic test_div_zero();
    do_txn(4'd0, 3'd0, 1'b0, 1, 0, 0, "x0_y0");
    do_txn(4'd7, 3'd0, 1'b0, 1, 0, 0, "x7_y0");
  endtask

  task automatic test_sweep();
    for (int xi = 1; xi <= 15; xi++) begin
      for (int yi = 4; yi <= 7; yi++) begin
        do_txn(4'(xi), 3'(yi), (xi % yi) == 0, (xi / yi) + 1, 3, 0, "sweep");
      end
    end
  endtask

  task automatic test_back_to_back();
    do_txn(4'd6, 3'd3, 1'b1, 3, 0, 3, "hold_x6_y3");
    do_txn(4'd9, 3'd2, 1'b0, 5, 0, 0, "next_x9_y2");
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    x = 4'd15; y = 3'd1; dav_ = 1'b0;
    @(posedge clock); #1;
    dav_ = 1'b1;
    @(posedge clock); #1;
    reset_ = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (rfd !== 1'b1 || ok !== 1'b0 || m !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: rfd=%b ok=%b m=%b required rfd=1 ok=0 m=0", rfd, ok, m);
    end
    reset_ = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (rfd !== 1'b1 || ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: rfd=%b ok=%b required rfd=1 ok=0", rfd, ok);
    end
    do_txn(4'd14, 3'd7, 1'b1, 3, 0, 0, "after_reset_x14_y7");
  endtask

  initial begin
    checks = 0; errors = 0; ok_rises = 0; txns = 0; ok_prev = 1'b0;
    reset_ = 1'b0; dav_ = 1'b1; x = '0; y = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_sweep();
    test_reset_mid();
    repeat (2) @(posedge clock);
    #3;
    checks++;
    if (ok_rises != txns) begin
      errors++;
      $display("FAIL ok_rise_count: got %0d required %0d", ok_rises, txns);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
